// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the iterative DIV/DIVU sequencer.
// The state encoding is shared between the controller and any code that observes it.
package div_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } divState_e;

   localparam int DIV_STEPS = 32;

endpackage

// File: rtl/div_sequencer_div_step.sv
// One radix-2 restoring division step on a {remainder, quotient} pair.
// The quotient half shifts in dividend bits MSB first and receives the new quotient bit at its LSB.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] remQuo,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] nextRemQuo
);

   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;
   logic           fits;

   // The trial remainder needs one extra bit: the shifted value can reach 2*divisor-1.
   always_comb begin
      trial      = {remQuo[2*WIDTH-1:WIDTH], remQuo[WIDTH-1]};
      diff       = trial - {1'b0, divisor};
      fits       = (trial >= {1'b0, divisor});
      nextRemQuo = {(fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0]),
                    remQuo[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller for the execute stage: stalls E, runs 32 restoring
// steps on operand magnitudes, sign-corrects in FIX, and holds the result until E advances.
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             annul_i,
   input  logic             advance_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);

   divState_e              state;
   divState_e              nextState;
   logic [CNT_W-1:0]       cnt;
   logic [WIDTH-1:0]       divisor;
   logic [2*WIDTH-1:0]     remQuo;
   logic [2*WIDTH-1:0]     nextRemQuo;
   logic                   signedOp;
   logic                   signA;
   logic                   signB;
   logic                   divZero;
   logic                   launch;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic takeAbs);
      logic signed [WIDTH-1:0] sv;
      sv = $signed(v);
      if (takeAbs && sv[WIDTH-1]) return $unsigned(-sv);
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v,
                                                  input logic negate);
      logic signed [WIDTH-1:0] sv;
      sv = $signed(v);
      if (negate) return $unsigned(-sv);
      return v;
   endfunction

   assign launch = start_i & ~annul_i;

   div_step #(.WIDTH(WIDTH)) uStep (
      .remQuo     (remQuo),
      .divisor    (divisor),
      .nextRemQuo (nextRemQuo)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= nextState;
   end

   // DONE waits for advance_i so a start_i still held by a frozen E cannot relaunch.
   always_comb begin
      nextState = state;
      if (annul_i) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE: if (start_i) nextState = RUN;
            RUN:  if (cnt == CNT_W'(WIDTH-1)) nextState = FIX;
            FIX:  nextState = DONE;
            DONE: if (advance_i) nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   always_comb begin
      stall_o = start_i & ~annul_i & (state != DONE);
      busy_o  = (state == RUN) || (state == FIX);
      valid_o = (state == DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)             cnt <= '0;
      else if (state == IDLE)  cnt <= '0;
      else if (state == RUN)   cnt <= cnt + CNT_W'(1);
   end

   // Operand capture in IDLE; the quotient half of remQuo starts out holding |a|.
   always_ff @(posedge clk) begin
      if (state == IDLE && launch) begin
         divisor  <= magnitude(b_i, signed_i);
         remQuo   <= {{WIDTH{1'b0}}, magnitude(a_i, signed_i)};
         signedOp <= signed_i;
         signA    <= signed_i & a_i[WIDTH-1];
         signB    <= signed_i & b_i[WIDTH-1];
         divZero  <= (b_i == '0);
      end else if (state == RUN) begin
         remQuo   <= nextRemQuo;
      end
   end

   // With b==0 every step subtracts zero, so the remainder is |a| and its sign fix restores a.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lo_o <= '0;
         hi_o <= '0;
      end else if (state == FIX && !annul_i) begin
         lo_o <= divZero ? '1 : applySign(remQuo[WIDTH-1:0], signedOp & (signA ^ signB));
         hi_o <= applySign(remQuo[2*WIDTH-1:WIDTH], signA);
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random divides
// compared against an arithmetic reference model.
module tb_div_sequencer;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        sgn;
   logic [31:0] a;
   logic [31:0] b;
   logic        annul;
   logic        advance;
   logic        stall;
   logic        busy;
   logic        valid;
   logic [31:0] lo;
   logic [31:0] hi;

   int checks   = 0;
   int failures = 0;

   div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start_i   (start),
      .signed_i  (sgn),
      .a_i       (a),
      .b_i       (b),
      .annul_i   (annul),
      .advance_i (advance),
      .stall_o   (stall),
      .busy_o    (busy),
      .valid_o   (valid),
      .lo_o      (lo),
      .hi_o      (hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference: truncating division, remainder follows dividend, results mod 2^32.
   task automatic model(input logic [31:0] opA, input logic [31:0] opB, input logic opS,
                        output logic [31:0] eLo, output logic [31:0] eHi);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] q;
      logic signed [63:0] r;
      if (opB == 32'd0) begin
         eLo = 32'hFFFF_FFFF;
         eHi = opA;
      end else if (opS) begin
         sa  = {{32{opA[31]}}, opA};
         sb  = {{32{opB[31]}}, opB};
         q   = sa / sb;
         r   = sa % sb;
         eLo = q[31:0];
         eHi = r[31:0];
      end else begin
         eLo = opA / opB;
         eHi = opA % opB;
      end
   endtask

   // Launches from IDLE at the current cycle t; returns at t+34 with valid_o expected high.
   task automatic doOp(input logic [31:0] opA, input logic [31:0] opB, input logic opS,
                       input string name);
      logic [31:0] eLo;
      logic [31:0] eHi;
      model(opA, opB, opS, eLo, eHi);
      a = opA; b = opB; sgn = opS; start = 1'b1; annul = 1'b0; advance = 1'b0;
      #1;
      for (int c = 0; c < 34; c++) begin
         checks++;
         if ({stall, busy, valid} !== {1'b1, (c != 0), 1'b0}) begin
            failures++;
            $display("FAIL %s cycle t+%0d stall/busy/valid got %b expected %b",
                     name, c, {stall, busy, valid}, {1'b1, (c != 0), 1'b0});
         end
         tick();
         if (c == 0) begin
            a = $urandom; b = $urandom; sgn = ~sgn;
         end
      end
      checks++;
      if ({stall, busy, valid} !== 3'b001) begin
         failures++;
         $display("FAIL %s t+34 stall/busy/valid got %b expected 001", name, {stall, busy, valid});
      end
      checks++;
      if (lo !== eLo || hi !== eHi) begin
         failures++;
         $display("FAIL %s result lo=%h hi=%h expected lo=%h hi=%h", name, lo, hi, eLo, eHi);
      end
   endtask

   task automatic finishOp(input string name);
      start = 1'b0; advance = 1'b1;
      tick();
      advance = 1'b0;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s leave DONE valid=%b busy=%b expected 0 0", name, valid, busy);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0; annul = 1'b0; advance = 1'b0;
      #3;
      checks++;
      if ({stall, busy, valid} !== 3'b000 || lo !== 32'd0 || hi !== 32'd0) begin
         failures++;
         $display("FAIL reset stall/busy/valid=%b lo=%h hi=%h expected 000 0 0",
                  {stall, busy, valid}, lo, hi);
      end
      tick(); tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_divu_basic();
      doOp(32'd100, 32'd7, 1'b0, "divu_100_7");
      finishOp("divu_100_7");
   endtask

   task automatic test_signed();
      doOp(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
      finishOp("div_m7_2");
      doOp(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
      finishOp("div_7_m2");
      doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow");
      finishOp("div_overflow");
   endtask

   task automatic test_div_by_zero();
      doOp(32'd5, 32'd0, 1'b0, "divu_by_zero");
      finishOp("divu_by_zero");
      doOp(32'hFFFF_FFF0, 32'd0, 1'b1, "div_neg_by_zero");
      finishOp("div_neg_by_zero");
   endtask

   task automatic test_annul();
      a = 32'd1000; b = 32'd3; sgn = 1'b0; start = 1'b1;
      for (int c = 0; c < 11; c++) begin
         tick();
         checks++;
         if (valid !== 1'b0) begin
            failures++;
            $display("FAIL annul_run valid=%b expected 0", valid);
         end
      end
      annul = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL annul_cycle stall=%b busy=%b expected 0 1", stall, busy);
      end
      tick();
      annul = 1'b0;
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         failures++;
         $display("FAIL annul_idle busy=%b valid=%b expected 0 0", busy, valid);
      end
      doOp(32'd9, 32'd4, 1'b0, "after_annul");
      finishOp("after_annul");
   endtask

   task automatic test_hold_done();
      logic [31:0] heldLo;
      logic [31:0] heldHi;
      doOp(32'd12345, 32'd99, 1'b0, "hold");
      heldLo = lo; heldHi = hi;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({stall, busy, valid} !== 3'b001 || lo !== heldLo || hi !== heldHi) begin
            failures++;
            $display("FAIL hold cycle %0d stall/busy/valid=%b lo=%h hi=%h expected 001 %h %h",
                     c, {stall, busy, valid}, lo, hi, heldLo, heldHi);
         end
      end
      finishOp("hold");
   endtask

   task automatic test_back_to_back();
      doOp(32'd1000, 32'd33, 1'b0, "b2b_first");
      advance = 1'b1;
      a = 32'hFFFF_FF9C; b = 32'd7;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL b2b_advance stall=%b expected 0", stall);
      end
      tick();
      doOp(32'hFFFF_FF9C, 32'd7, 1'b1, "b2b_second");
      finishOp("b2b_second");
   endtask

   task automatic test_async_reset();
      a = 32'd77777; b = 32'd13; sgn = 1'b0; start = 1'b1;
      for (int c = 0; c < 21; c++) tick();
      resetn = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || lo !== 32'd0 || hi !== 32'd0) begin
         failures++;
         $display("FAIL async_reset busy=%b valid=%b lo=%h hi=%h expected 0 0 0 0",
                  busy, valid, lo, hi);
      end
      tick();
      resetn = 1'b1;
      doOp(32'd77777, 32'd13, 1'b0, "after_reset");
      finishOp("after_reset");
   endtask

   task automatic test_random();
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      for (int n = 0; n < 24; n++) begin
         ra = $urandom;
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0:       rb = $urandom;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'd0 - $urandom_range(1, 15);
            3:       rb = $urandom >> $urandom_range(0, 31);
            default: rb = (n % 6 == 0) ? 32'd0 : $urandom_range(1, 100000);
         endcase
         doOp(ra, rb, rs, "random");
         finishOp("random");
      end
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_signed();
      test_div_by_zero();
      test_annul();
      test_hold_done();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
